// File: rtl/sincos_sched.sv
// Round-robin scheduler sharing one pipelined sincos unit among NUM_REQ requesters.
// A requester tag rides alongside each angle so every result goes back to the requester that issued it.
module sincos_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ANGLE_W = 27,
    parameter int DATA_W  = 27,
    parameter int LATENCY = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ANGLE_W-1:0]   req_angle,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         sc_en,
    output logic [ANGLE_W-1:0]           sc_angle,
    input  logic [DATA_W-1:0]            sc_sin,
    input  logic [DATA_W-1:0]            sc_cos,
    output logic [NUM_REQ-1:0]           res_valid,
    output logic [ID_W-1:0]              res_id,
    output logic [DATA_W-1:0]            res_sin,
    output logic [DATA_W-1:0]            res_cos,
    output logic                         busy
);

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        id_onehot = NUM_REQ'(1) << id;
    endfunction

    logic [ID_W-1:0]              ptr_r;
    logic [ANGLE_W-1:0]           sc_angle_r;
    // Stage 0 travels with sc_angle; stage LATENCY lines up with sc_sin/sc_cos.
    logic [LATENCY:0]             tag_vld_r;
    logic [LATENCY:0][ID_W-1:0]   tag_id_r;

    logic [NUM_REQ-1:0]           res_valid_r;
    logic [ID_W-1:0]              res_id_r;
    logic [DATA_W-1:0]            res_sin_r;
    logic [DATA_W-1:0]            res_cos_r;

    logic [ANGLE_W-1:0]           angle_arr_s [NUM_REQ];
    logic [ID_W-1:0]              idx_s;
    logic [ID_W-1:0]              grant_id_s;
    logic                         any_valid_s;
    logic                         issue_s;
    logic [NUM_REQ-1:0]           grant_s;

    // Unpack the flat angle bus so the granted angle can be picked by tag.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            angle_arr_s[k] = req_angle[k*ANGLE_W +: ANGLE_W];
        end
    end

    // Round-robin search starting just past the pointer; scanning backwards lets the nearest candidate win.
    always_comb begin
        idx_s       = '0;
        grant_id_s  = '0;
        any_valid_s = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx_s       = ID_W'((int'(ptr_r) + i) % NUM_REQ);
            grant_id_s  = req_valid[idx_s] ? idx_s : grant_id_s;
            any_valid_s = any_valid_s | req_valid[idx_s];
        end
        issue_s = en & any_valid_s;
        grant_s = issue_s ? id_onehot(grant_id_s) : '0;
    end

    // Issue register, round-robin pointer and tag pipeline; all freeze while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r      <= ID_W'(NUM_REQ - 1);
            sc_angle_r <= '0;
            tag_vld_r  <= '0;
            tag_id_r   <= '0;
        end else if (en) begin
            tag_vld_r <= {tag_vld_r[LATENCY-1:0], issue_s};
            tag_id_r  <= {tag_id_r[LATENCY-1:0], grant_id_s};
            if (issue_s) begin
                sc_angle_r <= angle_arr_s[grant_id_s];
                ptr_r      <= grant_id_s;
            end
        end
    end

    // Result capture; strobe only on enabled edges so a stall never repeats a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_r <= '0;
            res_id_r    <= '0;
            res_sin_r   <= '0;
            res_cos_r   <= '0;
        end else if (en && tag_vld_r[LATENCY]) begin
            res_valid_r <= id_onehot(tag_id_r[LATENCY]);
            res_id_r    <= tag_id_r[LATENCY];
            res_sin_r   <= sc_sin;
            res_cos_r   <= sc_cos;
        end else begin
            res_valid_r <= '0;
        end
    end

    assign req_ready = grant_s;
    assign sc_en     = en;
    assign sc_angle  = sc_angle_r;
    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;
    assign res_sin   = res_sin_r;
    assign res_cos   = res_cos_r;
    assign busy      = |tag_vld_r;

endmodule

// File: tb/tb_sincos_sched.sv
// Directed bench for sincos_sched with a simple LATENCY-deep stand-in for the sincos unit.
module tb_sincos_sched;

    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int AW  = 27;
    localparam int DW  = 27;
    localparam int LAT = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*AW-1:0]  req_angle = '0;
    logic [NR-1:0]     req_ready;
    logic              sc_en;
    logic [AW-1:0]     sc_angle;
    logic [DW-1:0]     sc_sin;
    logic [DW-1:0]     sc_cos;
    logic [NR-1:0]     res_valid;
    logic [IW-1:0]     res_id;
    logic [DW-1:0]     res_sin;
    logic [DW-1:0]     res_cos;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int strobes;

    sincos_sched #(.NUM_REQ(NR), .ID_W(IW), .ANGLE_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .sc_en(sc_en), .sc_angle(sc_angle), .sc_sin(sc_sin), .sc_cos(sc_cos),
        .res_valid(res_valid), .res_id(res_id), .res_sin(res_sin), .res_cos(res_cos),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] f_sin(input logic [AW-1:0] a);
        f_sin = a ^ 27'h5A5A5A5;
    endfunction

    function automatic logic [DW-1:0] f_cos(input logic [AW-1:0] a);
        f_cos = ~a;
    endfunction

    // Stand-in sincos: LATENCY enabled cycles from sc_angle to its result.
    logic [AW-1:0] pipe [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (sc_en) begin
            pipe[0] <= sc_angle;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign sc_sin = f_sin(pipe[LAT-1]);
    assign sc_cos = f_cos(pipe[LAT-1]);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_angle(input int k, input logic [AW-1:0] a);
        req_angle[k*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic count_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (res_valid != '0) strobes++;
        end
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_sc_angle", 64'(sc_angle), 64'(0));
        check("rst_res_sin", 64'(res_sin), 64'(0));
        tick();
        rst = 1'b0;
        #1;

        // Single request from requester 1
        req_valid = 4'b0010;
        set_angle(1, 27'h0000100);
        #1;
        check("t1_ready", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = 4'b0000;
        #1;
        check("t1_sc_angle", 64'(sc_angle), 64'(27'h0000100));
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_ready_off", 64'(req_ready), 64'(0));
        strobes = 0;
        count_strobes(LAT);
        check("t1_early", 64'(strobes), 64'(0));
        tick();
        check("t1_res_valid", 64'(res_valid), 64'(4'b0010));
        check("t1_res_id", 64'(res_id), 64'(1));
        check("t1_res_sin", 64'(res_sin), 64'(f_sin(27'h0000100)));
        check("t1_res_cos", 64'(res_cos), 64'(f_cos(27'h0000100)));
        tick();
        check("t1_res_drop", 64'(res_valid), 64'(0));
        check("t1_busy_off", 64'(busy), 64'(0));

        // Full contention after reset: grants rotate 0,1,2,3,...
        do_reset();
        for (int k = 0; k < NR; k++) set_angle(k, AW'(32'h40 + 32'(k)));
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_grant", 64'(req_ready), 64'(4'b0001 << (i % 4)));
            tick();
        end
        req_valid = 4'b0000;
        for (int i = 0; i < LAT - 7; i++) tick();
        check("t2_before", 64'(res_valid), 64'(0));
        tick();
        for (int j = 0; j < 8; j++) begin
            check("t2_res_valid", 64'(res_valid), 64'(4'b0001 << (j % 4)));
            check("t2_res_id", 64'(res_id), 64'(j % 4));
            check("t2_res_sin", 64'(res_sin), 64'(f_sin(AW'(32'h40 + 32'(j % 4)))));
            tick();
        end
        check("t2_after", 64'(res_valid), 64'(0));

        // Stall of 5 cycles mid-flight
        req_valid = 4'b0001;
        set_angle(0, 27'h1234567);
        #1;
        check("t3_ready", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        en = 1'b0;
        req_valid = 4'b0100;
        #1;
        check("t3_stall_ready", 64'(req_ready), 64'(0));
        for (int i = 0; i < 5; i++) tick();
        check("t3_stall_ready_end", 64'(req_ready), 64'(0));
        en = 1'b1;
        req_valid = 4'b0000;
        strobes = 0;
        count_strobes(16);
        check("t3_early", 64'(strobes), 64'(0));
        tick();
        check("t3_res_valid", 64'(res_valid), 64'(4'b0001));
        check("t3_res_cos", 64'(res_cos), 64'(f_cos(27'h1234567)));
        tick();
        check("t3_once", 64'(res_valid), 64'(0));

        // Pointer fairness with wrap: 2, then 0, then 2
        set_angle(0, 27'h0000AAA);
        set_angle(2, 27'h0000BBB);
        req_valid = 4'b0100;
        #1;
        check("t4_g2", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid = 4'b0101;
        #1;
        check("t4_g0", 64'(req_ready), 64'(4'b0001));
        tick();
        check("t4_g2b", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < LAT - 1; i++) tick();
        check("t4_r2", 64'(res_valid), 64'(4'b0100));
        check("t4_r2_sin", 64'(res_sin), 64'(f_sin(27'h0000BBB)));
        tick();
        check("t4_r0", 64'(res_valid), 64'(4'b0001));
        check("t4_r0_sin", 64'(res_sin), 64'(f_sin(27'h0000AAA)));
        tick();
        check("t4_r2b", 64'(res_valid), 64'(4'b0100));

        // Mid-flight reset discards everything in the pipe
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        req_valid = 4'b0000;
        tick();
        tick();
        check("t5_busy_pre", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_res_valid", 64'(res_valid), 64'(0));
        check("t5_sc_angle", 64'(sc_angle), 64'(0));
        check("t5_res_id", 64'(res_id), 64'(0));
        tick();
        rst = 1'b0;
        strobes = 0;
        count_strobes(LAT + 2);
        check("t5_no_res", 64'(strobes), 64'(0));
        req_valid = 4'b1010;
        #1;
        check("t5_first_grant", 64'(req_ready), 64'(4'b0010));
        req_valid = 4'b0000;
        #1;

        // Back-to-back single requester, angles 0..9
        req_valid = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            set_angle(3, AW'(i));
            #1;
            check("t6_ready", 64'(req_ready), 64'(4'b1000));
            tick();
        end
        req_valid = 4'b0000;
        for (int i = 0; i < LAT - 8; i++) tick();
        for (int j = 0; j < 10; j++) begin
            check("t6_res_valid", 64'(res_valid), 64'(4'b1000));
            check("t6_res_sin", 64'(res_sin), 64'(f_sin(AW'(j))));
            tick();
        end
        check("t6_done", 64'(res_valid), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
